// File: rtl/slicem_wr_arbiter.sv
// Two-requester arbiter that turns each granted word into WORD_W single-bit writes on a SLICEM distributed-RAM port.
// Define SLICEM_WR_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module slicem_wr_arbiter #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = MUX_LVLS + 1 + S_XX_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [ADDR_W-1:0]    req_addr_0,
  input  logic [ADDR_W-1:0]    req_addr_1,
  input  logic [WORD_W-1:0]    req_data_0,
  input  logic [WORD_W-1:0]    req_data_1,
  output logic [1:0]           ack,
  output logic                 busy,
  output logic [MUX_LVLS-1:0]  higher_order_addr,
  output logic                 write_lut_select,
  output logic [S_XX_BASE-1:0] lut_addr,
  output logic                 data_in,
  output logic                 write_en
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK} state_t;

  state_t            state;
  logic              grant;
  logic              win;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt;

`ifdef SLICEM_WR_FIXED_PRIO_EN
  function automatic logic pick_grant(input logic [1:0] r);
    return ~r[0];
  endfunction

  assign win = pick_grant(req);
`else
  logic rr_ptr;

  // On contention the pointer names the winner; a lone requester always wins.
  function automatic logic pick_grant(input logic [1:0] r, input logic ptr);
    logic g;
    case (r)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
      default: g = ptr;
    endcase
    return g;
  endfunction

  assign win = pick_grant(req, rr_ptr);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= 1'b0;
      ack       <= 2'b00;
      busy      <= 1'b0;
      write_en  <= 1'b0;
      cur_addr  <= '0;
      shift_reg <= '0;
      cnt       <= '0;
`ifndef SLICEM_WR_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack <= 2'b00;
          if (|req) begin
            grant     <= win;
            cur_addr  <= win ? req_addr_1 : req_addr_0;
            shift_reg <= win ? req_data_1 : req_data_0;
            cnt       <= '0;
            write_en  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_WRITE;
          end
        end
        // Last bit is left in place so address and data hold once write_en drops.
        S_WRITE: begin
          if (cnt == LAST_CNT) begin
            write_en <= 1'b0;
            ack      <= grant ? 2'b10 : 2'b01;
            state    <= S_ACK;
          end else begin
            shift_reg <= shift_reg >> 1;
            cur_addr  <= cur_addr + ADDR_W'(1);
            cnt       <= cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          ack   <= 2'b00;
          busy  <= 1'b0;
`ifndef SLICEM_WR_FIXED_PRIO_EN
          rr_ptr <= ~grant;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign higher_order_addr = cur_addr[ADDR_W-1 -: MUX_LVLS];
  assign write_lut_select  = cur_addr[S_XX_BASE];
  assign lut_addr          = cur_addr[S_XX_BASE-1:0];
  assign data_in           = shift_reg[0];

endmodule

// File: tb/tb_slicem_wr_arbiter.sv
// Randomised self-checking bench for slicem_wr_arbiter against an arithmetic reference of the write sequence.
module tb_slicem_wr_arbiter;
  localparam int S_XX_BASE = 4;
  localparam int NUM_LUTS  = 4;
  localparam int MUX_LVLS  = 2;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 7;
  localparam int ASPACE    = 1 << ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req;
  logic [ADDR_W-1:0]    req_addr_0, req_addr_1;
  logic [WORD_W-1:0]    req_data_0, req_data_1;
  logic [1:0]           ack;
  logic                 busy;
  logic [MUX_LVLS-1:0]  higher_order_addr;
  logic                 write_lut_select;
  logic [S_XX_BASE-1:0] lut_addr;
  logic                 data_in;
  logic                 write_en;

  always #5 clk = ~clk;

  slicem_wr_arbiter #(
    .S_XX_BASE(S_XX_BASE), .NUM_LUTS(NUM_LUTS), .MUX_LVLS(MUX_LVLS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .ack(ack), .busy(busy), .higher_order_addr(higher_order_addr),
    .write_lut_select(write_lut_select), .lut_addr(lut_addr),
    .data_in(data_in), .write_en(write_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_pref = 0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic              obs_bit[$];
  int                obs_first;
  int                obs_busy_bad;
  logic [1:0]        obs_ack;
  logic              obs_ack_busy;

  function automatic int exp_winner(input logic [1:0] r);
`ifdef SLICEM_WR_FIXED_PRIO_EN
    return r[0] ? 0 : 1;
`else
    if (r == 2'b11) return m_pref;
    return r[0] ? 0 : 1;
`endif
  endfunction

  function automatic int exp_addr(input int start, input int k);
    return (start + k) % ASPACE;
  endfunction

  function automatic logic exp_bit(input int data, input int k);
    return logic'((data >> k) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records one write burst: cycles until write_en, each written address/bit, then ack in the following cycle.
  task automatic collect_op(input bit scramble);
    int c;
    obs_addr.delete();
    obs_bit.delete();
    obs_first = 0;
    obs_busy_bad = 0;
    obs_ack = 2'bxx;
    obs_ack_busy = 1'bx;
    c = 0;
    do begin
      tick();
      c++;
    end while (!write_en && c < 64);
    if (!write_en) return;
    obs_first = c;
    while (write_en && obs_addr.size() < WORD_W + 4) begin
      obs_addr.push_back({higher_order_addr, write_lut_select, lut_addr});
      obs_bit.push_back(data_in);
      if (!busy) obs_busy_bad++;
      if (scramble && obs_addr.size() == 1) begin
        req        = 2'($urandom);
        req_addr_0 = ADDR_W'($urandom);
        req_addr_1 = ADDR_W'($urandom);
        req_data_0 = WORD_W'($urandom);
        req_data_1 = WORD_W'($urandom);
      end
      tick();
    end
    obs_ack = ack;
    obs_ack_busy = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    m_pref = 0;
  endtask

  task automatic test_reset();
    int bad_idle;
    rst = 1'b1;
    req = 2'b00;
    req_addr_0 = '0; req_addr_1 = '0; req_data_0 = '0; req_data_1 = '0;
    tick();
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_bad++; $display("FAIL reset_write_en: got %b want 0", write_en); end
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if ({higher_order_addr, write_lut_select, lut_addr, data_in} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%h data_in=%b want 0/0",
               {higher_order_addr, write_lut_select, lut_addr}, data_in);
    end
    rst = 1'b0;
    m_pref = 0;
    bad_idle = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_en !== 1'b0 || ack !== 2'b00 || busy !== 1'b0) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad_idle); end
  endtask

  task automatic test_basic();
    int sa, sd;
    sa = 'h00; sd = 'hA5C3;
    req_addr_0 = ADDR_W'(sa); req_data_0 = WORD_W'(sd); req = 2'b01;
    collect_op(1'b0);
    req = 2'b00;
    n_cmp++; if (obs_first !== 1) begin n_bad++; $display("FAIL basic_latency: got %0d want 1", obs_first); end
    n_cmp++; if (obs_addr.size() !== WORD_W) begin n_bad++; $display("FAIL basic_len: got %0d want %0d", obs_addr.size(), WORD_W); end
    for (int k = 0; k < obs_addr.size() && k < WORD_W; k++) begin
      n_cmp++;
      if (obs_addr[k] !== ADDR_W'(exp_addr(sa, k)) || obs_bit[k] !== exp_bit(sd, k)) begin
        n_bad++;
        $display("FAIL basic_wr[%0d]: got addr=%h bit=%b want addr=%h bit=%b",
                 k, obs_addr[k], obs_bit[k], exp_addr(sa, k), exp_bit(sd, k));
      end
    end
    n_cmp++; if (obs_ack !== 2'b01 || obs_ack_busy !== 1'b1) begin n_bad++; $display("FAIL basic_ack: got ack=%b busy=%b want 01/1", obs_ack, obs_ack_busy); end
    n_cmp++; if (obs_busy_bad !== 0) begin n_bad++; $display("FAIL basic_busy: got %0d low cycles want 0", obs_busy_bad); end
    m_pref = 1;
    tick();
    n_cmp++; if (ack !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_ack_pulse: got ack=%b busy=%b want 00/0", ack, busy); end
    n_cmp++;
    if ({higher_order_addr, write_lut_select, lut_addr} !== ADDR_W'(exp_addr(sa, WORD_W - 1)) || data_in !== exp_bit(sd, WORD_W - 1)) begin
      n_bad++;
      $display("FAIL basic_hold: got addr=%h bit=%b want addr=%h bit=%b",
               {higher_order_addr, write_lut_select, lut_addr}, data_in, exp_addr(sa, WORD_W - 1), exp_bit(sd, WORD_W - 1));
    end
    tick();
  endtask

  task automatic test_round_robin();
    int sa0, sa1, sd0, sd1, w, sa, sd;
    do_reset();
    sa0 = $urandom_range(0, ASPACE - 1); sa1 = $urandom_range(0, ASPACE - 1);
    sd0 = $urandom_range(0, 65535);      sd1 = $urandom_range(0, 65535);
    req_addr_0 = ADDR_W'(sa0); req_addr_1 = ADDR_W'(sa1);
    req_data_0 = WORD_W'(sd0); req_data_1 = WORD_W'(sd1);
    req = 2'b11;
    for (int op = 0; op < 4; op++) begin
      w = exp_winner(2'b11);
      sa = w ? sa1 : sa0;
      sd = w ? sd1 : sd0;
      collect_op(1'b0);
      n_cmp++; if (obs_first !== (op == 0 ? 1 : 2)) begin n_bad++; $display("FAIL rr_latency[%0d]: got %0d want %0d", op, obs_first, op == 0 ? 1 : 2); end
      n_cmp++; if (obs_ack !== (w ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant[%0d]: got ack=%b want winner %0d", op, obs_ack, w); end
      n_cmp++; if (obs_addr.size() !== WORD_W) begin n_bad++; $display("FAIL rr_len[%0d]: got %0d want %0d", op, obs_addr.size(), WORD_W); end
      for (int k = 0; k < obs_addr.size() && k < WORD_W; k++) begin
        n_cmp++;
        if (obs_addr[k] !== ADDR_W'(exp_addr(sa, k)) || obs_bit[k] !== exp_bit(sd, k)) begin
          n_bad++;
          $display("FAIL rr_wr[%0d][%0d]: got addr=%h bit=%b want addr=%h bit=%b",
                   op, k, obs_addr[k], obs_bit[k], exp_addr(sa, k), exp_bit(sd, k));
        end
      end
      m_pref = 1 - w;
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_boundary(input int sa, input string tag);
    int sd;
    sd = $urandom_range(0, 65535);
    req_addr_1 = ADDR_W'(sa); req_data_1 = WORD_W'(sd); req = 2'b10;
    collect_op(1'b0);
    req = 2'b00;
    n_cmp++; if (obs_addr.size() !== WORD_W) begin n_bad++; $display("FAIL %s_len: got %0d want %0d", tag, obs_addr.size(), WORD_W); end
    for (int k = 0; k < obs_addr.size() && k < WORD_W; k++) begin
      n_cmp++;
      if (obs_addr[k] !== ADDR_W'(exp_addr(sa, k)) || obs_bit[k] !== exp_bit(sd, k)) begin
        n_bad++;
        $display("FAIL %s_wr[%0d]: got addr=%h bit=%b want addr=%h bit=%b",
                 tag, k, obs_addr[k], obs_bit[k], exp_addr(sa, k), exp_bit(sd, k));
      end
    end
    n_cmp++; if (obs_ack !== 2'b10) begin n_bad++; $display("FAIL %s_ack: got %b want 10", tag, obs_ack); end
    m_pref = 0;
    tick();
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL %s_ack_once: got %b want 00", tag, ack); end
    tick();
  endtask

  task automatic test_rst_mid();
    int wc, c, sa, sd, ack_seen;
    logic [1:0] first_ack;
    req_addr_0 = ADDR_W'($urandom); req_data_0 = WORD_W'($urandom); req = 2'b01;
    wc = 0; c = 0;
    while (wc < 5 && c < 64) begin
      tick();
      c++;
      if (write_en) wc++;
    end
    n_cmp++; if (wc !== 5) begin n_bad++; $display("FAIL rstmid_reach: got %0d write cycles want 5", wc); end
    rst = 1'b1;
    req = 2'b00;
    tick();
    n_cmp++; if (write_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_write_en: got %b want 0", write_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL rstmid_ack: got %b want 00", ack); end
    rst = 1'b0;
    m_pref = 0;
    sa = $urandom_range(0, ASPACE - 1); sd = $urandom_range(0, 65535);
    req_addr_1 = ADDR_W'(sa); req_data_1 = WORD_W'(sd); req = 2'b10;
    tick();
    n_cmp++;
    if (write_en !== 1'b1 || {higher_order_addr, write_lut_select, lut_addr} !== ADDR_W'(sa) || data_in !== exp_bit(sd, 0)) begin
      n_bad++;
      $display("FAIL rstmid_regrant: got we=%b addr=%h bit=%b want 1/%h/%b",
               write_en, {higher_order_addr, write_lut_select, lut_addr}, data_in, sa, exp_bit(sd, 0));
    end
    ack_seen = 0; first_ack = 2'b00; c = 0;
    while (ack_seen == 0 && c < 40) begin
      tick();
      c++;
      if (ack !== 2'b00) begin ack_seen = c; first_ack = ack; end
    end
    n_cmp++; if (first_ack !== 2'b10) begin n_bad++; $display("FAIL rstmid_ack_after: got %b want 10", first_ack); end
    n_cmp++; if (ack_seen !== WORD_W) begin n_bad++; $display("FAIL rstmid_ack_cycle: got %0d want %0d", ack_seen, WORD_W); end
    req = 2'b00;
    m_pref = 0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int w, sa, sd, r;
    do_reset();
    for (int op = 0; op < 12; op++) begin
      r = $urandom_range(1, 3);
      req_addr_0 = ADDR_W'($urandom); req_addr_1 = ADDR_W'($urandom);
      req_data_0 = WORD_W'($urandom); req_data_1 = WORD_W'($urandom);
      req = 2'(r);
      w  = exp_winner(2'(r));
      sa = w ? int'(req_addr_1) : int'(req_addr_0);
      sd = w ? int'(req_data_1) : int'(req_data_0);
      collect_op(1'b1);
      n_cmp++; if (obs_first !== (op == 0 ? 1 : 2)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", op, obs_first, op == 0 ? 1 : 2); end
      n_cmp++; if (obs_ack !== (w ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rand_grant[%0d]: req=%0d got ack=%b want winner %0d", op, r, obs_ack, w); end
      n_cmp++; if (obs_addr.size() !== WORD_W) begin n_bad++; $display("FAIL rand_len[%0d]: got %0d want %0d", op, obs_addr.size(), WORD_W); end
      for (int k = 0; k < obs_addr.size() && k < WORD_W; k++) begin
        n_cmp++;
        if (obs_addr[k] !== ADDR_W'(exp_addr(sa, k)) || obs_bit[k] !== exp_bit(sd, k)) begin
          n_bad++;
          $display("FAIL rand_wr[%0d][%0d]: got addr=%h bit=%b want addr=%h bit=%b",
                   op, k, obs_addr[k], obs_bit[k], exp_addr(sa, k), exp_bit(sd, k));
        end
      end
      m_pref = 1 - w;
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    req_addr_0 = '0; req_addr_1 = '0; req_data_0 = '0; req_data_1 = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_boundary('h3C, "lutcross");
    test_boundary('h78, "wrap");
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
